// File: rtl/nest_keyword_checker_pkg.sv
// Shared types and helpers for the nested keyword checker.
// Holds the keyword id enum, tokenizer state enum, token payload struct,
// error cause codes, opener/closer type encoding and ASCII letter helpers.
package nest_keyword_checker_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ERR_W  = 2;

  typedef enum logic [2:0] {
    KW_NONE,
    KW_BEGIN,
    KW_END,
    KW_CASE,
    KW_ENDCASE
  } kw_id_e;

  // One state per keyword prefix, plus the between-words and non-keyword states
  typedef enum logic [4:0] {
    S_SEP,
    S_OTHER,
    S_B, S_BE, S_BEG, S_BEGI, S_BEGIN,
    S_E, S_EN, S_END,
    S_ENDC, S_ENDCA, S_ENDCAS, S_ENDCASE,
    S_C, S_CA, S_CAS, S_CASE
  } tok_state_e;

  // Keyword committed on the separator that ends a word
  typedef struct packed {
    logic   valid;
    kw_id_e id;
  } kw_tok_t;

  localparam logic [ERR_W-1:0] ERR_NONE      = 2'd0;
  localparam logic [ERR_W-1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [ERR_W-1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [ERR_W-1:0] ERR_MISMATCH  = 2'd3;

  // Type bit stored on the stack for each open block
  localparam logic TYPE_BEGIN = 1'b0;
  localparam logic TYPE_CASE  = 1'b1;

  function automatic logic is_letter(input logic [BYTE_W-1:0] b);
    return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  function automatic logic [BYTE_W-1:0] to_lower(input logic [BYTE_W-1:0] b);
    if ((b >= 8'h41) && (b <= 8'h5A)) begin
      return b | 8'h20;
    end
    return b;
  endfunction

  function automatic logic is_opener(input kw_id_e id);
    return (id == KW_BEGIN) || (id == KW_CASE);
  endfunction

  function automatic logic is_closer(input kw_id_e id);
    return (id == KW_END) || (id == KW_ENDCASE);
  endfunction

  // Stack type bit implied by a keyword (begin/end vs case/endcase)
  function automatic logic kw_type(input kw_id_e id);
    return ((id == KW_CASE) || (id == KW_ENDCASE)) ? TYPE_CASE : TYPE_BEGIN;
  endfunction

endpackage

// File: rtl/nest_keyword_checker_kw_tokenizer.sv
// Case-insensitive keyword tokenizer for an ASCII byte stream.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   i_valid, i_byte : byte consumed at the rising edge when i_valid=1
//   o_tok_c         : keyword committed by the separator currently on i_byte
//   o_pending_c     : keyword the partial word would be if it ended now
module nest_keyword_checker_kw_tokenizer
  import nest_keyword_checker_pkg::*;
#(
  parameter int unsigned PAIR2_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [BYTE_W-1:0] i_byte,
  output kw_tok_t           o_tok_c,
  output kw_id_e            o_pending_c
);

  localparam logic P2 = (PAIR2_EN != 32'd0);

  tok_state_e        r_state;
  tok_state_e        w_state_nxt;
  logic [BYTE_W-1:0] w_lc;

  // Exact-keyword states; every other state maps to no keyword
  function automatic kw_id_e state_id(input tok_state_e s);
    case (s)
      S_BEGIN:   return KW_BEGIN;
      S_END:     return KW_END;
      S_CASE:    return KW_CASE;
      S_ENDCASE: return KW_ENDCASE;
      default:   return KW_NONE;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_SEP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and commit; any letter that breaks a prefix falls to OTHER
  always_comb begin
    w_state_nxt   = r_state;
    o_tok_c.valid = 1'b0;
    o_tok_c.id    = KW_NONE;
    w_lc          = to_lower(i_byte);
    if (i_valid) begin
      if (is_letter(i_byte)) begin
        w_state_nxt = S_OTHER;
        case (r_state)
          S_SEP: begin
            if (w_lc == 8'h62)            w_state_nxt = S_B;
            else if (w_lc == 8'h65)       w_state_nxt = S_E;
            else if (w_lc == 8'h63 && P2) w_state_nxt = S_C;
          end
          S_B:      if (w_lc == 8'h65)       w_state_nxt = S_BE;
          S_BE:     if (w_lc == 8'h67)       w_state_nxt = S_BEG;
          S_BEG:    if (w_lc == 8'h69)       w_state_nxt = S_BEGI;
          S_BEGI:   if (w_lc == 8'h6E)       w_state_nxt = S_BEGIN;
          S_E:      if (w_lc == 8'h6E)       w_state_nxt = S_EN;
          S_EN:     if (w_lc == 8'h64)       w_state_nxt = S_END;
          S_END:    if (w_lc == 8'h63 && P2) w_state_nxt = S_ENDC;
          S_ENDC:   if (w_lc == 8'h61)       w_state_nxt = S_ENDCA;
          S_ENDCA:  if (w_lc == 8'h73)       w_state_nxt = S_ENDCAS;
          S_ENDCAS: if (w_lc == 8'h65)       w_state_nxt = S_ENDCASE;
          S_C:      if (w_lc == 8'h61)       w_state_nxt = S_CA;
          S_CA:     if (w_lc == 8'h73)       w_state_nxt = S_CAS;
          S_CAS:    if (w_lc == 8'h65)       w_state_nxt = S_CASE;
          default:  w_state_nxt = S_OTHER;
        endcase
      end else begin
        w_state_nxt   = S_SEP;
        o_tok_c.id    = state_id(r_state);
        o_tok_c.valid = (state_id(r_state) != KW_NONE);
      end
    end
  end

  assign o_pending_c = state_id(r_state);

endmodule

// File: rtl/nest_keyword_checker.sv
// Streaming checker for nested begin/end (and optionally case/endcase)
// keyword blocks in an ASCII byte stream.
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   in_valid, in : byte consumed at the rising edge when in_valid=1
//   result       : stream balanced and error-free if the current word ended now
//   depth        : committed nesting depth
//   err          : sticky error flag
//   err_code     : first error cause (none/underflow/overflow/mismatch)
module nest_keyword_checker
  import nest_keyword_checker_pkg::*;
#(
  parameter int unsigned DEPTH_W   = 8,
  parameter int unsigned MAX_DEPTH = 255,
  parameter int unsigned PAIR2_EN  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [BYTE_W-1:0]  in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err,
  output logic [ERR_W-1:0]   err_code
);

  localparam int unsigned IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [DEPTH_W-1:0]   r_depth;
  logic                 r_err;
  logic [ERR_W-1:0]     r_err_code;
  logic [MAX_DEPTH-1:0] r_stack;

  kw_tok_t              w_tok;
  kw_id_e               w_pending;
  logic                 w_top_type;
  logic [DEPTH_W-1:0]   w_depth_nxt;
  logic                 w_err_nxt;
  logic [ERR_W-1:0]     w_err_code_nxt;
  logic                 w_push;
  logic                 w_push_type;

  nest_keyword_checker_kw_tokenizer #(
    .PAIR2_EN (PAIR2_EN)
  ) u_tok (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (in_valid),
    .i_byte      (in),
    .o_tok_c     (w_tok),
    .o_pending_c (w_pending)
  );

  // Type of the innermost open block; meaningless (and unused) at depth 0
  assign w_top_type = (r_depth != '0) ? r_stack[IDX_W'(r_depth - DEPTH_W'(1))] : TYPE_BEGIN;

  // Commit action for a keyword ending at this edge; frozen once an error is latched
  always_comb begin
    w_depth_nxt    = r_depth;
    w_err_nxt      = r_err;
    w_err_code_nxt = r_err_code;
    w_push         = 1'b0;
    w_push_type    = kw_type(w_tok.id);
    if (w_tok.valid && !r_err) begin
      if (is_opener(w_tok.id)) begin
        if (r_depth == DEPTH_W'(MAX_DEPTH)) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_OVERFLOW;
        end else begin
          w_push      = 1'b1;
          w_depth_nxt = r_depth + DEPTH_W'(1);
        end
      end else if (is_closer(w_tok.id)) begin
        if (r_depth == '0) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_UNDERFLOW;
        end else if (w_top_type != kw_type(w_tok.id)) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_MISMATCH;
        end else begin
          w_depth_nxt = r_depth - DEPTH_W'(1);
        end
      end
    end
  end

  // Depth, error and type stack registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_depth    <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_stack    <= '0;
    end else begin
      r_depth    <= w_depth_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
      if (w_push) begin
        r_stack[IDX_W'(r_depth)] <= w_push_type;
      end
    end
  end

  // Tentative verdict: evaluate as if the partial word were terminated now
  always_comb begin
    if (is_opener(w_pending)) begin
      result = 1'b0;
    end else if (is_closer(w_pending)) begin
      result = !r_err && (r_depth == DEPTH_W'(1)) && (w_top_type == kw_type(w_pending));
    end else begin
      result = !r_err && (r_depth == '0);
    end
  end

  assign depth    = r_depth;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_nest_keyword_checker.sv
// Self-checking bench: three checker instances (default, shallow MAX_DEPTH=3,
// second pair disabled) share one stimulus stream and are compared every cycle
// against a word/stack reference model, plus directed scenario checks.
module tb_nest_keyword_checker;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_byte;

  logic       res0, res1, res2;
  logic [7:0] dep0, dep2;
  logic [1:0] dep1;
  logic       err0, err1, err2;
  logic [1:0] code0, code1, code2;

  int n_checks;
  int n_fail;

  nest_keyword_checker #(.DEPTH_W(8), .MAX_DEPTH(255), .PAIR2_EN(1)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_byte),
    .result(res0), .depth(dep0), .err(err0), .err_code(code0));

  nest_keyword_checker #(.DEPTH_W(2), .MAX_DEPTH(3), .PAIR2_EN(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_byte),
    .result(res1), .depth(dep1), .err(err1), .err_code(code1));

  nest_keyword_checker #(.DEPTH_W(8), .MAX_DEPTH(255), .PAIR2_EN(0)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_byte),
    .result(res2), .depth(dep2), .err(err2), .err_code(code2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one slot per instance
  int    cfg_max [3] = '{255, 3, 255};
  bit    cfg_p2  [3] = '{1'b1, 1'b1, 1'b0};
  string m_word  [3];
  int    m_dep   [3];
  bit    m_err   [3];
  int    m_code  [3];
  bit    m_stk   [3][256];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit tb_letter(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  // 0 none, 1 begin, 2 end, 3 case, 4 endcase
  function automatic int kw_of(input string w, input bit p2);
    if (w == "begin") return 1;
    if (w == "end") return 2;
    if (p2 && w == "case") return 3;
    if (p2 && w == "endcase") return 4;
    return 0;
  endfunction

  function automatic void model_edge(input bit rst_n, input bit v, input logic [7:0] b);
    int id;
    bit typ;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_word[i] = "";
        m_dep[i]  = 0;
        m_err[i]  = 1'b0;
        m_code[i] = 0;
      end else if (v) begin
        if (tb_letter(b)) begin
          if (m_word[i].len() < 8) m_word[i] = $sformatf("%s%c", m_word[i], b | 8'h20);
        end else begin
          id = kw_of(m_word[i], cfg_p2[i]);
          m_word[i] = "";
          typ = (id >= 3);
          if (!m_err[i] && (id == 1 || id == 3)) begin
            if (m_dep[i] == cfg_max[i]) begin
              m_err[i] = 1'b1; m_code[i] = 2;
            end else begin
              m_stk[i][m_dep[i]] = typ;
              m_dep[i]++;
            end
          end else if (!m_err[i] && (id == 2 || id == 4)) begin
            if (m_dep[i] == 0) begin
              m_err[i] = 1'b1; m_code[i] = 1;
            end else if (m_stk[i][m_dep[i]-1] != typ) begin
              m_err[i] = 1'b1; m_code[i] = 3;
            end else begin
              m_dep[i]--;
            end
          end
        end
      end
    end
  endfunction

  function automatic int model_result(input int i);
    int id;
    id = kw_of(m_word[i], cfg_p2[i]);
    if (id == 1 || id == 3) return 0;
    if (id == 2 || id == 4)
      return int'(!m_err[i] && m_dep[i] == 1 && m_stk[i][0] == (id == 4));
    return int'(!m_err[i] && m_dep[i] == 0);
  endfunction

  function automatic int dut_res(input int i);
    case (i) 0: return int'(res0); 1: return int'(res1); default: return int'(res2); endcase
  endfunction
  function automatic int dut_dep(input int i);
    case (i) 0: return int'(dep0); 1: return int'(dep1); default: return int'(dep2); endcase
  endfunction
  function automatic int dut_err(input int i);
    case (i) 0: return int'(err0); 1: return int'(err1); default: return int'(err2); endcase
  endfunction
  function automatic int dut_code(input int i);
    case (i) 0: return int'(code0); 1: return int'(code1); default: return int'(code2); endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.result", i), dut_res(i), model_result(i));
      check($sformatf("u%0d.depth", i), dut_dep(i), m_dep[i]);
      check($sformatf("u%0d.err", i), dut_err(i), int'(m_err[i]));
      check($sformatf("u%0d.err_code", i), dut_code(i), m_code[i]);
    end
  endtask

  // Drive one cycle from a falling edge; model follows the rising edge
  task automatic cycle(input bit rst_n, input bit v, input logic [7:0] b);
    reset    = rst_n;
    in_valid = v;
    in_byte  = b;
    @(posedge clk);
    model_edge(rst_n, v, b);
    @(negedge clk);
    check_all();
  endtask

  task automatic send_str(input string s);
    for (int k = 0; k < s.len(); k++) cycle(1'b1, 1'b1, s[k]);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 8'h00);
  endtask

  string toks [16] = '{"begin", "end", "case", "endcase", "BEGIN", "End", "CaSe",
                       "ENDcase", "beginx", "ends", "x", "endc", "cas", "b",
                       "begin", "Begin"};
  string seps [6]  = '{" ", ";", "\n", "1", "@", "  "};

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string tok;
    string sep;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    @(negedge clk);
    do_reset();
    do_reset();
    check("rst.result", int'(res0), 1);
    check("rst.depth", int'(dep0), 0);
    check("rst.err_code", int'(code0), 0);

    // Plan 1
    send_str("Begin");
    check("t1.res_pending_begin", int'(res0), 0);
    send_str(" x END");
    check("t1.depth_before_sep", int'(dep0), 1);
    check("t1.res_pending_end", int'(res0), 1);
    send_str(" ");
    check("t1.depth_final", int'(dep0), 0);
    check("t1.err", int'(err0), 0);

    // Plan 2
    do_reset();
    send_str("end ");
    check("t2.err", int'(err0), 1);
    check("t2.err_code", int'(code0), 1);
    send_str("begin ");
    check("t2.depth_frozen", int'(dep0), 0);
    check("t2.result", int'(res0), 0);

    // Plan 3
    do_reset();
    send_str("case begin endcase ");
    check("t3.err_code", int'(code0), 3);
    check("t3.depth_frozen", int'(dep0), 2);
    check("t3.p2off_depth", int'(dep2), 1);
    check("t3.p2off_err", int'(err2), 0);
    do_reset();
    send_str("case begin end endcase ");
    check("t3b.depth", int'(dep0), 0);
    check("t3b.result", int'(res0), 1);

    // Plan 4
    do_reset();
    for (int k = 0; k < 4; k++) send_str("begin;");
    check("t4.err_code", int'(code1), 2);
    check("t4.depth", int'(dep1), 3);
    check("t4.wide_depth", int'(dep0), 4);

    // Plan 5, with idle cycles splitting a word
    do_reset();
    send_str("beg");
    cycle(1'b1, 1'b0, 8'h20);
    cycle(1'b1, 1'b0, 8'h3B);
    send_str("in");
    check("t5.res_pending", int'(res0), 0);
    send_str("x ends xbegin;");
    check("t5.depth", int'(dep0), 0);
    check("t5.result", int'(res0), 1);

    // Plan 6
    do_reset();
    send_str("begin begin beg");
    check("t6.depth_pre", int'(dep0), 2);
    cycle(1'b0, 1'b1, 8'h69);
    check("t6.depth_rst", int'(dep0), 0);
    check("t6.result_rst", int'(res0), 1);
    send_str("in ");
    check("t6.depth_after", int'(dep0), 0);
    check("t6.err_after", int'(err0), 0);

    // Random token streams with idle cycles, stray bytes and occasional resets
    do_reset();
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 39) == 0) cycle(1'b0, 1'($urandom_range(0, 1)), 8'h62);
      if ($urandom_range(0, 9) == 0) cycle(1'b1, 1'b1, 8'($urandom));
      tok = toks[$urandom_range(0, 15)];
      sep = seps[$urandom_range(0, 5)];
      for (int k = 0; k < tok.len(); k++) begin
        if ($urandom_range(0, 4) == 0) cycle(1'b1, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b1, tok[k]);
      end
      send_str(sep);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nest_keyword_checker.md
Name: nest_keyword_checker

Overview:
Streaming, case-insensitive checker for nested keyword blocks in an ASCII byte stream, one byte per accepted cycle.
Generalises the begin/end balance checker in four ways: parametrised depth, an optional second pair (case/endcase) tracked on a type stack, any non-letter byte acting as a separator, and a valid qualifier.
Reports a running balance verdict, the committed nesting depth, and the first error with its cause.
Sits on the character-stream side of the text-processing blocks.

Parameters:
DEPTH_W, 8, width of the depth counter and of the depth output
MAX_DEPTH, 255, maximum legal nesting depth (must be ≤ 2^DEPTH_W-1); also the type-stack size
PAIR2_EN, 1, 1 = case/endcase recognised as a second pair; 0 = those words are ordinary words

Ports:
clk  in  1  clock
reset  in  1  one clock; reset is synchronous and active-low
in_valid  in  1  byte on in is consumed at this rising edge
in  in  8  ASCII byte
result  out  1  1 = stream so far is balanced and error-free (tentative view, see below)
depth  out  DEPTH_W  committed nesting depth
err  out  1  sticky error flag
err_code  out  2  first error cause: 0 none, 1 underflow, 2 overflow, 3 type mismatch

Behaviour:
- Reset (reset==0 at a rising edge):
  - depth=0, err=0, err_code=0, type stack cleared.
  - Tokenizer returns to SEP with no partial word.
  - result=1 after reset.
  - Reset has priority over in_valid.
- in_valid=0: no state changes.
- Letters are A-Z and a-z, compared case-insensitively. Every other byte value is a separator.
- A word is a maximal run of letters.
- Tokenizer FSM states:
  - SEP: between words.
  - MATCH(prefix): letters so far are a prefix of a keyword. Prefixes of "begin", "end", "case", "endcase"; the last two only when PAIR2_EN=1.
  - OTHER: word is not a keyword. Stays until a separator arrives.
- Letter transitions:
  - A letter in SEP enters MATCH or OTHER.
  - A letter in MATCH extends the prefix or falls to OTHER.
  - "end" followed by 'c' continues toward "endcase" when PAIR2_EN=1.
- Commit on separator:
  - A separator byte ends the word.
  - If the word equals a keyword exactly, it is committed at that edge.
  - The separator itself is not part of any word.
- Commit actions, applied only when err==0:
  - begin or case (opener):
    - If depth==MAX_DEPTH: err=1, err_code=2, depth unchanged.
    - Otherwise push the opener type (0=begin, 1=case) at index depth, then depth+1.
  - end or endcase (closer):
    - If depth==0: err=1, err_code=1.
    - Otherwise, if the top-of-stack type differs from the closer type: err=1, err_code=3, depth unchanged.
    - Otherwise pop and depth-1.
- After err=1:
  - depth and the stack are frozen.
  - err_code holds the first cause.
  - The tokenizer keeps running. Only reset clears the error.
- Latency: depth, err and err_code update at the rising edge that consumes the separator. Each is visible in the following cycle.
- result is combinational from registers, as if the current word ended now:
  - Pending opener: result=0, since depth would be nonzero.
  - Pending closer: result=1 only if err==0, depth==1 and the top type matches the closer.
  - Otherwise: result = (err==0 && depth==0).
- Boundaries:
  - A keyword embedded in a longer word is not a keyword: "beginx", "xend" and "ends" are ignored.
  - "endcase" with PAIR2_EN=0 is an ordinary word.
  - Back-to-back separators have no effect.
  - Depth never wraps, because of the overflow check.
  - Reset mid-word discards the partial word.

Decomposition:
- Shared package:
  - Keyword id enum: NONE, BEGIN, END, CASE, ENDCASE.
  - err_code constants.
  - Opener type bit encoding.
  - The is_letter/to_lower helpers.
- Sub-module kw_tokenizer: owns the tokenizer FSM.
  - Outputs kw_commit (1-cycle pulse with its id) on the separator.
  - Outputs kw_pending (id of the exactly-matched partial word, or NONE).
- The top level holds the stack, the depth counter, the error logic and the result evaluation.

Test Plan:
1. Stream "Begin x END" → depth goes 1 then 0.
   - result=0 after "Begin", before the space.
   - result=1 after the final "D" (tentative view), with err=0 throughout.
2. Stream "end begin " → err=1, err_code=1 after the space following "end".
   - depth stays 0 and result=0 for the remainder of the stream.
3. With PAIR2_EN=1, stream "case begin endcase " → err_code=3 after "endcase" is committed.
   - depth=2 frozen.
   - The same stream with "end endcase " in place of "endcase " → depth 0, result=1.
4. With MAX_DEPTH=3, stream four "begin;" → err_code=2 on the 4th commit, depth=3.
5. Stream "beginx ends xbegin;" → no commits, depth=0, result=1.
   - in_valid=0 cycles inserted mid-word do not alter the tokenizer.
6. Drive reset=0 mid-word in "beg" after depth=2 → next cycle depth=0, err=0, result=1.
   - A subsequent "in " is treated as an ordinary word.
